// File: rtl/mysystem_sysid_checker.sv
// Boot-time sysid reader: reads ID (addr 0) then timestamp (addr 1) and compares them to build values.
// Latency: start sampled at edge N -> done after edge N+5 with a zero-wait slave and 1-cycle readdatavalid.
// Backpressure: request held stable while m_waitrequest=1; per-read timeout with bounded full-sequence retries.
module mysystem_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1457435403,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter logic [3:0]  MAX_RETRIES        = 4'd3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout_err,
  output logic [3:0]  retry_count
);

  typedef enum logic [2:0] {
    IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt;
  logic        auto_pend;
  logic        accept_start;
  logic        cap_id, cap_ts;
  logic        step_tmo, tmo_retry, tmo_fail;
  logic        do_check, enter_req;
  logic        timed_out, in_read, can_retry;

  assign timed_out = (tmo_cnt == TIMEOUT_CYCLES);
  assign in_read   = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                     (state_q == TS_REQ) || (state_q == TS_WAIT);
  assign can_retry = (retry_count < MAX_RETRIES);

  // Outputs decoded from state only, so reset drops m_read without waiting for a clock.
  assign m_read    = (state_q == ID_REQ) || (state_q == TS_REQ);
  assign m_address = (state_q == TS_REQ);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and step decode; a read completing on the timeout edge wins over the timeout.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    cap_id       = 1'b0;
    cap_ts       = 1'b0;
    step_tmo     = 1'b0;
    do_check     = 1'b0;
    tmo_retry    = 1'b0;
    tmo_fail     = 1'b0;
    enter_req    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || auto_pend) begin
          accept_start = 1'b1;
          state_d      = ID_REQ;
        end
      end
      ID_REQ: begin
        if (!m_waitrequest && m_readdatavalid) begin
          cap_id  = 1'b1;
          state_d = TS_REQ;
        end else if (timed_out) begin
          step_tmo = 1'b1;
        end else if (!m_waitrequest) begin
          state_d = ID_WAIT;
        end
      end
      ID_WAIT: begin
        if (m_readdatavalid) begin
          cap_id  = 1'b1;
          state_d = TS_REQ;
        end else if (timed_out) begin
          step_tmo = 1'b1;
        end
      end
      TS_REQ: begin
        if (!m_waitrequest && m_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = CHECK;
        end else if (timed_out) begin
          step_tmo = 1'b1;
        end else if (!m_waitrequest) begin
          state_d = TS_WAIT;
        end
      end
      TS_WAIT: begin
        if (m_readdatavalid) begin
          cap_ts  = 1'b1;
          state_d = CHECK;
        end else if (timed_out) begin
          step_tmo = 1'b1;
        end
      end
      CHECK: begin
        do_check = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = ID_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    tmo_retry = step_tmo && can_retry;
    tmo_fail  = step_tmo && !can_retry;
    if (tmo_retry) state_d = ID_REQ;
    if (tmo_fail)  state_d = DONE;
    enter_req = accept_start || cap_id || tmo_retry;
  end

  // Per-read timeout counter, restarted on every entry to a request state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       tmo_cnt <= 16'd0;
    else if (enter_req) tmo_cnt <= 16'd0;
    else if (in_read)   tmo_cnt <= tmo_cnt + 16'd1;
  end

  // One-shot auto start on the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_pend <= AUTO_START;
    else          auto_pend <= 1'b0;
  end

  // Captured words, retry count and verdict flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
      retry_count <= 4'd0;
    end else if (accept_start) begin
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
      retry_count <= 4'd0;
    end else begin
      if (cap_id)    id_value    <= m_readdata;
      if (cap_ts)    ts_value    <= m_readdata;
      if (tmo_retry) retry_count <= retry_count + 4'd1;
      if (tmo_fail) begin
        fail        <= 1'b1;
        timeout_err <= 1'b1;
      end
      if (do_check) begin
        pass <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
        fail <= !((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP));
      end
    end
  end

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// Bench for the sysid checker: plans each read (stall, data delay, data), expands it into a per-cycle trace.
// The trace carries slave inputs and expected outputs; one negedge process compares every cycle.
// Directed sequences pin latency and verdicts with literal values, then randomized sequences follow.
module tb_mysystem_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457435403;
  localparam int          T      = 8;
  localparam int          MAXR   = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        busy, done, pass, fail, timeout_err;
  logic [3:0]  retry_count;

  always #5 clock = ~clock;

  mysystem_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (16'd8),
    .MAX_RETRIES        (4'd2),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail            (fail),
    .timeout_err     (timeout_err),
    .retry_count     (retry_count)
  );

  typedef struct {
    logic        start, wr, dv;
    logic [31:0] rd;
    logic        e_read, e_addr, e_busy, e_done, e_pass, e_fail, e_to;
    logic [3:0]  e_rc;
    logic [31:0] e_id, e_ts;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   cur_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model state: what the outputs must show during the cycle being planned.
  logic        x_busy, x_done, x_pass, x_fail, x_to, x_read, x_addr;
  logic [3:0]  x_rc;
  logic [31:0] x_id, x_ts;
  int          seq_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    x_busy = 0; x_done = 0; x_pass = 0; x_fail = 0; x_to = 0;
    x_read = 0; x_addr = 0; x_rc = 0; x_id = 0; x_ts = 0;
  endtask

  task automatic push(input logic st, input logic wr, input logic dv, input logic [31:0] rd);
    cyc_t c;
    c.start = st; c.wr = wr; c.dv = dv; c.rd = rd;
    c.e_read = x_read; c.e_addr = x_addr; c.e_busy = x_busy; c.e_done = x_done;
    c.e_pass = x_pass; c.e_fail = x_fail; c.e_to = x_to; c.e_rc = x_rc;
    c.e_id = x_id; c.e_ts = x_ts;
    q.push_back(c);
    seq_cyc++;
  endtask

  function automatic logic noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // One read: w stalled cycles, data d cycles after the accept; it lasts until data or the timeout edge.
  task automatic attempt(input bit is_ts, input int w, input int d, input logic [31:0] data,
                         input bit force_st, output bit ok);
    int last;
    last = ((w + d) < T) ? (w + d) : T;
    for (int i = 0; i <= last; i++) begin
      x_read = (i <= w);
      x_addr = is_ts && (i <= w);
      push(force_st || ($urandom_range(0, 9) == 0), (i < w), (i == w + d),
           (i == w + d) ? data : $urandom);
    end
    x_read = 0;
    x_addr = 0;
    ok = ((w + d) <= T);
  endtask

  task automatic pick(input int mode, input bit ts, input int att,
                      output int w, output int d, output logic [31:0] data);
    int r;
    data = ts ? EXP_TS : EXP_ID;
    w = 0;
    d = 1;
    case (mode)
      2: if (ts) data = EXP_TS + 32'd1;
      3: w = 3;
      4: d = 100;
      5: d = (att == 0) ? 100 : 1;
      6: d = ts ? 5 : 1;
      0: begin
        w = $urandom_range(0, 5);
        r = $urandom_range(0, 7);
        if (r == 0)      d = 50;
        else if (r <= 2) d = 8 - w + $urandom_range(0, 1);
        else             d = $urandom_range(0, 3);
        if ($urandom_range(0, 4) == 0) data = $urandom;
      end
      default: ;
    endcase
  endtask

  // Plans a whole sequence: start cycle, reads with retries, CHECK, then a few DONE cycles.
  task automatic run_seq(input int mode, input bit auto_st, output int lat);
    int w, d, att;
    bit ok, ts_phase, fin, fs;
    logic [31:0] data;
    fs = (mode == 5);
    seq_cyc = 0;
    push(!auto_st, 1'b0, noise(), $urandom);
    model_clear();
    x_busy = 1;
    ts_phase = 0; att = 0; fin = 0;
    while (!fin) begin
      pick(mode, ts_phase, att, w, d, data);
      attempt(ts_phase, w, d, data, fs, ok);
      att++;
      if (!ok) begin
        if (x_rc < MAXR) begin
          x_rc++;
          ts_phase = 0;
        end else begin
          x_fail = 1; x_to = 1; fin = 1;
        end
      end else if (!ts_phase) begin
        x_id = data;
        ts_phase = 1;
      end else begin
        x_ts = data;
        push(fs || ($urandom_range(0, 3) == 0), 1'b0, noise(), $urandom);
        x_pass = (x_id == EXP_ID) && (x_ts == EXP_TS);
        x_fail = !x_pass;
        fin = 1;
      end
    end
    x_busy = 0;
    x_done = 1;
    lat = seq_cyc - 1;
    repeat ($urandom_range(1, 3)) push(1'b0, 1'b0, noise(), $urandom);
  endtask

  task automatic play(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      c = q.pop_front();
      start = c.start;
      m_waitrequest = c.wr;
      m_readdatavalid = c.dv;
      m_readdata = c.rd;
      cur = c;
      cur_vld = 1'b1;
    end
  endtask

  // Per-cycle comparison of every output against the planned trace.
  always @(negedge clock) begin
    if (cur_vld) begin
      chk("m_read", {31'd0, m_read}, {31'd0, cur.e_read});
      if (cur.e_read) chk("m_address", {31'd0, m_address}, {31'd0, cur.e_addr});
      chk("busy", {31'd0, busy}, {31'd0, cur.e_busy});
      chk("done", {31'd0, done}, {31'd0, cur.e_done});
      chk("pass", {31'd0, pass}, {31'd0, cur.e_pass});
      chk("fail", {31'd0, fail}, {31'd0, cur.e_fail});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, cur.e_to});
      chk("retry_count", {28'd0, retry_count}, {28'd0, cur.e_rc});
      chk("id_value", id_value, cur.e_id);
      chk("ts_value", ts_value, cur.e_ts);
    end
  end

  initial begin
    int lat;
    reset_n = 1'b1;
    start = 0; m_waitrequest = 0; m_readdatavalid = 0; m_readdata = 0;
    model_clear();
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_m_read", {31'd0, m_read}, 32'd0);
    chk("rst_retry", {28'd0, retry_count}, 32'd0);

    // Auto start, nominal slave.
    run_seq(1, 1'b1, lat);
    chk("lat_nominal", lat, 5);
    play(q.size());
    @(negedge clock);
    chk("s1_pass", {31'd0, pass}, 32'd1);
    chk("s1_fail", {31'd0, fail}, 32'd0);
    chk("s1_ts", ts_value, 32'd1457435403);

    // Wrong timestamp.
    run_seq(2, 1'b0, lat);
    chk("lat_badts", lat, 5);
    play(q.size());
    @(negedge clock);
    chk("s2_fail", {31'd0, fail}, 32'd1);
    chk("s2_to", {31'd0, timeout_err}, 32'd0);
    chk("s2_ts", ts_value, 32'd1457435404);

    // Three stall cycles per request.
    run_seq(3, 1'b0, lat);
    chk("lat_stall", lat, 11);
    play(q.size());
    @(negedge clock);
    chk("s3_pass", {31'd0, pass}, 32'd1);

    // Slave never returns data.
    run_seq(4, 1'b0, lat);
    chk("lat_timeout", lat, 27);
    play(q.size());
    @(negedge clock);
    chk("s4_fail", {31'd0, fail}, 32'd1);
    chk("s4_to", {31'd0, timeout_err}, 32'd1);
    chk("s4_retry", {28'd0, retry_count}, 32'd2);

    // First ID read times out, start hammered while busy.
    run_seq(5, 1'b0, lat);
    chk("lat_retry1", lat, 14);
    play(q.size());
    @(negedge clock);
    chk("s5_retry", {28'd0, retry_count}, 32'd1);
    chk("s5_pass", {31'd0, pass}, 32'd1);

    // Start from DONE clears flags and reruns.
    run_seq(1, 1'b0, lat);
    play(q.size());
    @(negedge clock);
    chk("s5b_retry", {28'd0, retry_count}, 32'd0);
    chk("s5b_pass", {31'd0, pass}, 32'd1);

    // Reset while in TS_WAIT.
    run_seq(6, 1'b0, lat);
    play(5);
    chk("s6_busy_pre", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    cur_vld = 1'b0;
    #1;
    chk("s6_busy", {31'd0, busy}, 32'd0);
    chk("s6_m_read", {31'd0, m_read}, 32'd0);
    chk("s6_id", id_value, 32'd0);
    chk("s6_done", {31'd0, done}, 32'd0);
    q.delete();
    model_clear();
    repeat (2) @(negedge clock);
    run_seq(1, 1'b1, lat);
    play(q.size());
    @(negedge clock);
    chk("s6_rerun_pass", {31'd0, pass}, 32'd1);

    // Randomized sequences.
    for (int s = 0; s < 40; s++) begin
      run_seq(0, 1'b0, lat);
      play(q.size());
    end
    @(negedge clock);
    cur_vld = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
